// File: rtl/div_pkg.sv
// Shared constants and types for the divider result BCD converter.
// The DIV_BCD_SIGNED_EN build option is handled in div_result_bcd.
package div_pkg;

    localparam int DIV_W          = 10;
    localparam int DIV_BCD_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_Q = 2'd1,
        CONV_R = 2'd2,
        DONE   = 2'd3
    } div_state_t;

    typedef logic [4*DIV_BCD_DIGITS-1:0] bcd_t;

    // Constant-evaluable 10^n, used to size-check the BCD result width.
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble step: add 3 to every digit >= 5, then shift left taking in one binary bit.
module bcd_dd_step #(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] acc,
    input  logic                bit_in,
    output logic [4*DIGITS-1:0] acc_shifted
);

    logic [4*DIGITS-1:0] acc_corr;

    // Corrections happen before the shift, so no carry ever crosses a digit.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit = acc[4*gi +: 4];
            assign acc_corr[4*gi +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
        end
    endgenerate

    assign acc_shifted = (4*DIGITS)'({acc_corr, bit_in});

endmodule

// File: rtl/div_result_bcd.sv
// Sequential double-dabble converter for divider quotient/remainder, quotient first.
// Build option: define DIV_BCD_SIGNED_EN to treat inputs as two's complement with sign flags.
module div_result_bcd
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_W,
    parameter int DIGITS = DIV_BCD_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    quo_in,
    input  logic [WIDTH-1:0]    rem_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] quo_bcd,
    output logic [4*DIGITS-1:0] rem_bcd,
    output logic                quo_neg,
    output logic                rem_neg
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

    generate
        if (pow10(DIGITS) <= MAX_BIN) begin : g_digits_too_small
            $error("div_result_bcd: DIGITS=%0d cannot hold %0d-bit values", DIGITS, WIDTH);
        end
    endgenerate

    div_state_t        state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]  quo_sh_reg, quo_sh_next;
    logic [WIDTH-1:0]  rem_sh_reg, rem_sh_next;
    logic [BW-1:0]     acc_reg, acc_next;
    logic [BW-1:0]     quo_hold_reg, quo_hold_next;
    logic [BW-1:0]     quo_bcd_reg, quo_bcd_next;
    logic [BW-1:0]     rem_bcd_reg, rem_bcd_next;
    logic              out_valid_reg, out_valid_next;
    logic              quo_sgn_reg, quo_sgn_next;
    logic              rem_sgn_reg, rem_sgn_next;
    logic              quo_neg_reg, quo_neg_next;
    logic              rem_neg_reg, rem_neg_next;

    logic [WIDTH-1:0]  quo_mag, rem_mag;
    logic              quo_sgn, rem_sgn;
    logic              step_bit;
    logic [BW-1:0]     acc_step;
    logic              last_step;

`ifdef DIV_BCD_SIGNED_EN
    // Two's-complement magnitude; the most negative value maps to its unsigned magnitude.
    assign quo_sgn = quo_in[WIDTH-1];
    assign rem_sgn = rem_in[WIDTH-1];
    assign quo_mag = quo_sgn ? (~quo_in + WIDTH'(1)) : quo_in;
    assign rem_mag = rem_sgn ? (~rem_in + WIDTH'(1)) : rem_in;
`else
    assign quo_sgn = 1'b0;
    assign rem_sgn = 1'b0;
    assign quo_mag = quo_in;
    assign rem_mag = rem_in;
`endif

    assign in_ready  = (state_reg == IDLE) && rst_n;
    assign step_bit  = (state_reg == CONV_R) ? rem_sh_reg[WIDTH-1] : quo_sh_reg[WIDTH-1];
    assign last_step = (cnt_reg == CW'(WIDTH - 1));

    bcd_dd_step #(
        .DIGITS (DIGITS)
    ) u_step (
        .acc         (acc_reg),
        .bit_in      (step_bit),
        .acc_shifted (acc_step)
    );

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        quo_sh_next    = quo_sh_reg;
        rem_sh_next    = rem_sh_reg;
        acc_next       = acc_reg;
        quo_hold_next  = quo_hold_reg;
        quo_bcd_next   = quo_bcd_reg;
        rem_bcd_next   = rem_bcd_reg;
        out_valid_next = out_valid_reg;
        quo_sgn_next   = quo_sgn_reg;
        rem_sgn_next   = rem_sgn_reg;
        quo_neg_next   = quo_neg_reg;
        rem_neg_next   = rem_neg_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready) begin
                    quo_sh_next  = quo_mag;
                    rem_sh_next  = rem_mag;
                    quo_sgn_next = quo_sgn;
                    rem_sgn_next = rem_sgn;
                    acc_next     = '0;
                    cnt_next     = '0;
                    state_next   = CONV_Q;
                end
            end
            CONV_Q: begin
                quo_sh_next = {quo_sh_reg[WIDTH-2:0], 1'b0};
                if (last_step) begin
                    quo_hold_next = acc_step;
                    acc_next      = '0;
                    cnt_next      = '0;
                    state_next    = CONV_R;
                end else begin
                    acc_next = acc_step;
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            CONV_R: begin
                rem_sh_next = {rem_sh_reg[WIDTH-2:0], 1'b0};
                if (last_step) begin
                    // Both results and their signs become visible on the same edge.
                    quo_bcd_next   = quo_hold_reg;
                    rem_bcd_next   = acc_step;
                    quo_neg_next   = quo_sgn_reg;
                    rem_neg_next   = rem_sgn_reg;
                    out_valid_next = 1'b1;
                    acc_next       = '0;
                    cnt_next       = '0;
                    state_next     = DONE;
                end else begin
                    acc_next = acc_step;
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            quo_sh_reg    <= '0;
            rem_sh_reg    <= '0;
            acc_reg       <= '0;
            quo_hold_reg  <= '0;
            quo_bcd_reg   <= '0;
            rem_bcd_reg   <= '0;
            out_valid_reg <= 1'b0;
            quo_sgn_reg   <= 1'b0;
            rem_sgn_reg   <= 1'b0;
            quo_neg_reg   <= 1'b0;
            rem_neg_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            quo_sh_reg    <= quo_sh_next;
            rem_sh_reg    <= rem_sh_next;
            acc_reg       <= acc_next;
            quo_hold_reg  <= quo_hold_next;
            quo_bcd_reg   <= quo_bcd_next;
            rem_bcd_reg   <= rem_bcd_next;
            out_valid_reg <= out_valid_next;
            quo_sgn_reg   <= quo_sgn_next;
            rem_sgn_reg   <= rem_sgn_next;
            quo_neg_reg   <= quo_neg_next;
            rem_neg_reg   <= rem_neg_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign quo_bcd   = quo_bcd_reg;
    assign rem_bcd   = rem_bcd_reg;
    assign quo_neg   = quo_neg_reg;
    assign rem_neg   = rem_neg_reg;

endmodule
